// File: rtl/dmem_lsu_pkg.sv
// Shared load/store op encodings, FSM state type and op-classification helpers.
// Latency: none (definitions only).
// Backpressure: n/a.
package dmem_lsu_pkg;

  // Encodings shared with the control unit's load_store_op output.
  typedef enum logic [2:0] {
    LS_LW  = 3'b000,
    LS_SB  = 3'b001,
    LS_SH  = 3'b010,
    LS_SW  = 3'b011,
    LS_LB  = 3'b100,
    LS_LH  = 3'b101,
    LS_LBU = 3'b110,
    LS_LHU = 3'b111
  } ls_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } lsu_state_e;

  function automatic logic op_is_store(input logic [2:0] op);
    return (op == LS_SB) || (op == LS_SH) || (op == LS_SW);
  endfunction

  function automatic logic op_is_half(input logic [2:0] op);
    return (op == LS_LH) || (op == LS_LHU) || (op == LS_SH);
  endfunction

  function automatic logic op_is_word(input logic [2:0] op);
    return (op == LS_LW) || (op == LS_SW);
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Word-addressed data-memory bus between the LSU (master) and the SRAM (slave).
// Latency: n/a (signal bundle).
// Backpressure: req is held by the master until the slave pulses ack.
interface dmem_lsu_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic             we;
  logic [WIDTH-3:0] addr;
  logic [3:0]       be;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface

// File: rtl/dmem_lsu_align.sv
// Byte-lane alignment: store byte enables/replication, load extraction/extension, misalign detect.
// Latency: purely combinational.
// Backpressure: none.
module dmem_lsu_align
  import dmem_lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [1:0]       a,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] wdata_lane,
  output logic [WIDTH-1:0] rdata_ext,
  output logic             misalign
);

  logic [WIDTH-1:0] shifted;

  // Move the addressed byte/half down to bit 0 before extension.
  assign shifted = mem_rdata >> {a, 3'b000};

  // Lane selection for stores and sign/zero extension for loads.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = shifted;
    misalign   = (op_is_half(op) && a[0]) || (op_is_word(op) && (a != 2'b00));
    case (op)
      LS_SB: begin
        be         = 4'b0001 << a;
        wdata_lane = {(WIDTH/8){wdata[7:0]}};
      end
      LS_SH: begin
        be         = 4'b0011 << a;
        wdata_lane = {(WIDTH/16){wdata[15:0]}};
      end
      LS_LB:  rdata_ext = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      LS_LBU: rdata_ext = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      LS_LH:  rdata_ext = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      LS_LHU: rdata_ext = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store responder: one access at a time over a req/ack word bus.
// Latency: done 2 cycles after enable with same-cycle ack; illegal access done after 1 cycle.
// Backpressure: holds mem req until ack or TIMEOUT; waits for both enables low before re-arming.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             DM_read_en,
  input  logic             DM_write_en,
  input  logic [2:0]       load_store_op,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             done,
  output logic             err,
  dmem_lsu_if.master       mem
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e       state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             we_q;
  logic             err_q;
  logic [CW-1:0]    cnt_q;

  logic             idle;
  logic             accept;
  logic             illegal;
  logic [2:0]       op_sel;
  logic [1:0]       a_sel;
  logic [3:0]       be;
  logic [WIDTH-1:0] wdata_lane;
  logic [WIDTH-1:0] rdata_ext;
  logic             misalign;

  assign idle   = (state_q == S_IDLE);
  assign accept = idle && (DM_read_en || DM_write_en);
  // In IDLE the aligner checks the live request; afterwards it works on the latched one.
  assign op_sel = idle ? load_store_op : op_q;
  assign a_sel  = idle ? addr[1:0]     : addr_q[1:0];

  assign illegal = (DM_read_en && DM_write_en)
                 || (DM_read_en  &&  op_is_store(load_store_op))
                 || (DM_write_en && !op_is_store(load_store_op))
                 || misalign;

  dmem_lsu_align #(.WIDTH(WIDTH)) u_align (
    .op         (op_sel),
    .a          (a_sel),
    .wdata      (wdata_q),
    .mem_rdata  (mem.rdata),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state and Moore outputs; the memory bus is driven only while in REQ.
  always_comb begin
    state_d   = state_q;
    done      = 1'b0;
    err       = 1'b0;
    mem.req   = 1'b0;
    mem.we    = 1'b0;
    mem.addr  = '0;
    mem.be    = 4'b0000;
    mem.wdata = '0;
    case (state_q)
      S_IDLE: if (accept) state_d = illegal ? S_RESP : S_REQ;
      S_REQ: begin
        mem.req   = 1'b1;
        mem.we    = we_q;
        mem.addr  = addr_q[WIDTH-1:2];
        mem.be    = be;
        mem.wdata = wdata_lane;
        if (mem.ack || (cnt_q == CNT_LAST)) state_d = S_RESP;
      end
      S_RESP: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_HOLD;
      end
      S_HOLD: if (!DM_read_en && !DM_write_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, timeout counting and load result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata   <= '0;
    end else if (accept) begin
      op_q    <= load_store_op;
      addr_q  <= addr;
      wdata_q <= wdata;
      we_q    <= DM_write_en;
      err_q   <= illegal;
      cnt_q   <= '0;
    end else if (state_q == S_REQ) begin
      cnt_q <= cnt_q + 1'b1;
      if (mem.ack) begin
        if (!we_q) rdata <= rdata_ext;
      end else if (cnt_q == CNT_LAST) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: scoreboard queue of expected responses, monitor checks on done.
// Latency: checks enable-to-done cycle counts for each access.
// Backpressure: the memory responder acks after a per-vector number of REQ cycles, or never.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        DM_read_en = 1'b0;
  logic        DM_write_en = 1'b0;
  logic [2:0]  load_store_op = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        done;
  logic        err;

  int n_vec = 0;
  int n_err = 0;
  resp_t exp_q[$];

  dmem_lsu_if #(.WIDTH(32)) mem_bus ();

  dmem_lsu #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .DM_read_en    (DM_read_en),
    .DM_write_en   (DM_write_en),
    .load_store_op (load_store_op),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .done          (done),
    .err           (err),
    .mem           (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL resp_unexpected: got done with rdata %h, expected no response", rdata);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", rdata, e.rdata);
        check("resp_err", {31'b0, err}, {31'b0, e.err});
      end
    end
  end

  // One access: ack_wait = REQ cycles before ack (-1 = never); hold = cycles enables stay high.
  task automatic run(input string nm, input logic rd, input logic wr, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] wd, input int ack_wait,
                     input logic [31:0] mrd, input int exp_req, input logic [3:0] exp_be,
                     input bit chk_wd, input logic [31:0] exp_wd, input logic [31:0] exp_rdata,
                     input logic exp_err, input int exp_lat, input int hold);
    int req_cycles = 0;
    int dones = 0;
    int lat = -1;
    bit stable = 1'b1;
    logic [3:0]  be0 = '0;
    logic [31:0] wd0 = '0;
    logic [29:0] ad0 = '0;
    @(posedge clk); #1;
    DM_read_en = rd; DM_write_en = wr; load_store_op = op; addr = a; wdata = wd;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (lat < 0) lat = c;
      end
      if (mem_bus.req) begin
        if (req_cycles == 0) begin
          be0 = mem_bus.be; wd0 = mem_bus.wdata; ad0 = mem_bus.addr;
          check({nm, "_be"}, {28'b0, mem_bus.be}, {28'b0, exp_be});
          check({nm, "_maddr"}, {2'b0, mem_bus.addr}, {2'b0, a[31:2]});
          check({nm, "_we"}, {31'b0, mem_bus.we}, {31'b0, wr});
          if (chk_wd) check({nm, "_wdata"}, mem_bus.wdata, exp_wd);
        end else if (mem_bus.be !== be0 || mem_bus.wdata !== wd0 || mem_bus.addr !== ad0) begin
          stable = 1'b0;
        end
        if (req_cycles == ack_wait) begin
          mem_bus.ack = 1'b1;
          mem_bus.rdata = mrd;
        end
        req_cycles++;
      end
      @(posedge clk); #1;
      mem_bus.ack = 1'b0;
      mem_bus.rdata = 32'h5A5A_5A5A;
      if (c + 1 == hold) begin
        DM_read_en = 1'b0;
        DM_write_en = 1'b0;
      end
    end
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_done_pulses"}, dones, 1);
    check({nm, "_req_cycles"}, req_cycles, exp_req);
    if (exp_req > 1) check({nm, "_req_stable"}, {31'b0, stable}, 32'd1);
  endtask

  initial begin
    int dones;
    int reqs;
    bit seen;
    mem_bus.ack = 1'b0;
    mem_bus.rdata = 32'h5A5A_5A5A;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_req", {31'b0, mem_bus.req}, 32'h0);
    check("rst_be", {28'b0, mem_bus.be}, 32'h0);
    rst = 1'b1;

    //   name       rd wr op      addr          wdata         ack mem_rdata    req be       wd? wdata exp     rdata exp    err lat hold
    run("lb",        1, 0, LS_LB,  32'h0000_0103, 32'h0,         0, 32'h80FF_1234, 1, 4'b1111, 0, 32'h0,          32'hFFFF_FF80, 0,  2, 3);
    run("lhu",       1, 0, LS_LHU, 32'h0000_0102, 32'h0,         0, 32'h8001_0000, 1, 4'b1111, 0, 32'h0,          32'h0000_8001, 0,  2, 3);
    run("lh",        1, 0, LS_LH,  32'h0000_0102, 32'h0,         0, 32'h8001_0000, 1, 4'b1111, 0, 32'h0,          32'hFFFF_8001, 0,  2, 3);
    run("lbu",       1, 0, LS_LBU, 32'h0000_0101, 32'h0,         0, 32'h0000_AB00, 1, 4'b1111, 0, 32'h0,          32'h0000_00AB, 0,  2, 3);
    run("sb",        0, 1, LS_SB,  32'h0000_0201, 32'h1234_56AB, 3, 32'h0,         4, 4'b0010, 1, 32'hABAB_ABAB,  32'h0000_00AB, 0,  5, 3);
    run("sh",        0, 1, LS_SH,  32'h0000_0402, 32'h0000_BEEF, 1, 32'h0,         2, 4'b1100, 1, 32'hBEEF_BEEF,  32'h0000_00AB, 0,  3, 3);
    run("lw_misal",  1, 0, LS_LW,  32'h0000_0302, 32'h0,        -1, 32'h0,         0, 4'b1111, 0, 32'h0,          32'h0000_00AB, 1,  1, 5);
    run("both_en",   1, 1, LS_LW,  32'h0000_0700, 32'h0,        -1, 32'h0,         0, 4'b1111, 0, 32'h0,          32'h0000_00AB, 1,  1, 2);
    run("rd_stop",   1, 0, LS_SB,  32'h0000_0701, 32'h0,        -1, 32'h0,         0, 4'b1111, 0, 32'h0,          32'h0000_00AB, 1,  1, 2);
    run("sw_tmo",    0, 1, LS_SW,  32'h0000_0400, 32'h1122_3344,-1, 32'h0,        16, 4'b1111, 1, 32'h1122_3344,  32'h0000_00AB, 1, 17, 3);
    run("lw",        1, 0, LS_LW,  32'h0000_0500, 32'h0,         0, 32'hDEAD_BEEF, 1, 4'b1111, 0, 32'h0,          32'hDEAD_BEEF, 0,  2, 3);

    // Reset in the middle of a request; a late ack must not produce a response.
    @(posedge clk); #1;
    DM_read_en = 1'b1; load_store_op = LS_LW; addr = 32'h0000_0600;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (mem_bus.req) seen = 1'b1;
    end
    check("rstreq_started", {31'b0, seen}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("rstreq_req", {31'b0, mem_bus.req}, 32'h0);
    check("rstreq_done", {31'b0, done}, 32'h0);
    check("rstreq_rdata", rdata, 32'h0);
    DM_read_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_bus.ack = 1'b1;
    mem_bus.rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_bus.ack = 1'b0;
    dones = 0;
    reqs = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (mem_bus.req) reqs++;
    end
    check("late_ack_done", dones, 0);
    check("late_ack_req", reqs, 0);
    check("late_ack_rdata", rdata, 32'h0);
    check("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
